uart_tx_buffered: RTL

- Downstream stage of the response handler: accepts the two-byte response stream (response code, then payload) as single-cycle byte strobes and serialises it to the client over UART 8N1, LSB first.
- Contains a 2-entry byte FIFO, so code and data bytes arriving on back-to-back or closely spaced strobes are never lost while a frame is on the line.
- Drives the FPGA's TX pin directly.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_tx_buffered_byte_fifo2.sv | 71 +++++++
 rtl/uart_tx_buffered.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the buffered UART transmitter:
//                FSM state encoding, default bit timing, data width and an
//                even-parity helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Transmitter FSM state encoding (PARITY is only reachable when
  // UART_TX_PARITY_EN is defined)
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 5208;  // 50 MHz / 9600 baud
  localparam int DATA_BITS            = 8;

  // Even parity over one data byte: 1 when the byte has an odd number of ones
  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_buffered_byte_fifo2.sv
`default_nettype none
// ============================================================================
//  Module      : byte_fifo2
//  Description : Two-entry synchronous byte FIFO. A push into a full FIFO is
//                still accepted when a pop happens on the same edge; any other
//                push into a full FIFO is dropped and flagged on drop_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo2
  import uart_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic [1:0]           count_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 drop_o
);

  localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

  logic [DATA_BITS-1:0] mem_q [2];
  logic                 wr_ptr_q;
  logic                 rd_ptr_q;
  logic [1:0]           count_q;

  logic                 w_pop;
  logic                 w_push;

  // A pop from an empty FIFO is ignored; a full FIFO makes room only if it pops
  assign w_pop   = pop_i && (count_q != 2'd0);
  assign w_push  = push_i && ((count_q != FULL_COUNT) || w_pop);
  assign drop_o  = push_i && !w_push;

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == 2'd0);

  // Storage array: written on every accepted push, not cleared by reset
  always_ff @(posedge clock_i) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (w_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_buffered
//  Description : Buffered UART transmitter (8N1, LSB first). Bytes arrive as
//                single-cycle strobes into a 2-entry FIFO and are serialised
//                back-to-back with no idle gap between queued frames.
//                Optional macro UART_TX_PARITY_EN inserts an even-parity bit
//                between the data bits and the stop bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 byte_valid,
  input  logic [DATA_BITS-1:0] byte_in,
  output logic                 buffer_full,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 overrun,
  output logic                 tx
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  // tx_done is registered, so it is set one cycle ahead of the last stop cycle
  localparam logic [15:0] BAUD_PRE  = 16'(CLKS_PER_BIT - 2);
  localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_e            state_q;
  logic [15:0]          baud_q;
  logic [2:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 tx_q;
  logic                 done_q;
  logic                 overrun_q;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  logic                 w_bit_end;
  logic                 w_pop;
  logic [DATA_BITS-1:0] w_head;
  logic [1:0]           w_count;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_drop;

  assign w_bit_end = (baud_q == BAUD_LAST);

  // The FIFO head is consumed when a frame starts from idle or when a stop
  // bit ends with more data waiting
  assign w_pop = !w_empty &&
                 ((state_q == ST_IDLE) || ((state_q == ST_STOP) && w_bit_end));

  byte_fifo2 #(
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clock_i (clock),
    .reset_i (reset),
    .push_i  (byte_valid),
    .pop_i   (w_pop),
    .data_i  (byte_in),
    .data_o  (w_head),
    .count_o (w_count),
    .full_o  (w_full),
    .empty_o (w_empty),
    .drop_o  (w_drop)
  );

  assign buffer_full = w_full;
  assign tx_busy     = (state_q != ST_IDLE) || (w_count != 2'd0);
  assign tx_done     = done_q;
  assign overrun     = overrun_q;
  assign tx          = tx_q;

  // Frame sequencer: bit timing, shift register and registered line outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      baud_q    <= 16'd0;
      bit_q     <= 3'd0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (w_drop) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= 16'd0;
          if (w_pop) begin
            shift_q  <= w_head;
`ifdef UART_TX_PARITY_EN
            parity_q <= even_parity(w_head);
`endif
            tx_q     <= 1'b0;
            state_q  <= ST_START;
          end
        end

        ST_START: begin
          if (w_bit_end) begin
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            tx_q    <= shift_q[0];
            state_q <= ST_DATA;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end

        ST_DATA: begin
          if (w_bit_end) begin
            baud_q  <= 16'd0;
            shift_q <= shift_q >> 1;
            if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= ST_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_bit_end) begin
            baud_q  <= 16'd0;
            tx_q    <= 1'b1;
            state_q <= ST_STOP;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
`endif

        ST_STOP: begin
          if (baud_q == BAUD_PRE) begin
            done_q <= 1'b1;
          end
          if (w_bit_end) begin
            baud_q <= 16'd0;
            if (w_pop) begin
              shift_q  <= w_head;
`ifdef UART_TX_PARITY_EN
              parity_q <= even_parity(w_head);
`endif
              tx_q     <= 1'b0;
              state_q  <= ST_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= ST_IDLE;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end

        default: begin
          baud_q  <= 16'd0;
          tx_q    <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
